uart_tx: RTL

- Serial UART transmitter: 8 data bits, LSB first, one start bit, one stop bit, no parity by default.
- Bit timing is set by CLKS_PER_BIT and must match the receiver on the same link.
- Bytes come from the host-side control logic through a valid/ready handshake.
- A one-entry holding register lets frames go out back-to-back with no idle gap; the serial output drives the board TX pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 23 ++
 rtl/uart_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width and parity helper.
// The receiver is expected to share this package as well.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } uart_state_e;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// every bit period; a synchronous clear holds it at zero.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 23
) (
    input  logic i_Clock,
    input  logic i_Clear,
    output logic o_Bit_End
);

    logic [7:0] r_count;

    assign o_Bit_End = (r_count == 8'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_Clock) begin
        if (i_Clear || o_Bit_End) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 with a one-entry holding register for gap-free frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 23
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Tx_DV,
    input  logic [UART_DATA_BITS-1:0] i_Tx_Byte,
    output logic                      o_Tx_Ready,
    output logic                      o_Tx_Serial,
    output logic                      o_Tx_Active,
    output logic                      o_Tx_Done
);

    uart_state_e               r_state;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_hold;
    logic                      r_hold_valid;
    logic [2:0]                r_bit_idx;

    logic                      w_accept;
    logic                      w_bit_end;
    logic                      w_cnt_clear;
    logic                      w_stop_end;
    logic [2:0]                w_next_idx;

    assign o_Tx_Ready  = !r_hold_valid;
    assign w_accept    = i_Tx_DV && !r_hold_valid;
    assign w_cnt_clear = i_Reset || (r_state == IDLE);
    assign w_stop_end  = (r_state == STOP) && w_bit_end;
    assign w_next_idx  = r_bit_idx + 3'd1;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .i_Clock  (i_Clock),
        .i_Clear  (w_cnt_clear),
        .o_Bit_End(w_bit_end)
    );

    // Outputs are registered from the next-state decision, so the line
    // changes on the edge that starts each bit.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_bit_idx    <= '0;
            o_Tx_Serial  <= 1'b1;
            o_Tx_Active  <= 1'b0;
            o_Tx_Done    <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;

            // A byte offered mid-frame is parked; the last STOP cycle takes it directly.
            if (w_accept && (r_state != IDLE) && !w_stop_end) begin
                r_hold       <= i_Tx_Byte;
                r_hold_valid <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    r_bit_idx   <= '0;
                    if (w_accept) begin
                        r_shift     <= i_Tx_Byte;
                        r_state     <= START;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                    end else if (r_hold_valid) begin
                        r_shift      <= r_hold;
                        r_hold_valid <= 1'b0;
                        r_state      <= START;
                        o_Tx_Serial  <= 1'b0;
                        o_Tx_Active  <= 1'b1;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_state     <= DATA;
                        r_bit_idx   <= '0;
                        o_Tx_Serial <= r_shift[0];
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state     <= PARITY;
                            o_Tx_Serial <= even_parity(r_shift);
`else
                            r_state     <= STOP;
                            o_Tx_Serial <= 1'b1;
`endif
                        end else begin
                            r_bit_idx   <= w_next_idx;
                            o_Tx_Serial <= r_shift[w_next_idx];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state     <= STOP;
                        o_Tx_Serial <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (w_bit_end) begin
                        o_Tx_Done <= 1'b1;
                        if (r_hold_valid) begin
                            r_shift      <= r_hold;
                            r_hold_valid <= 1'b0;
                            r_state      <= START;
                            o_Tx_Serial  <= 1'b0;
                        end else if (w_accept) begin
                            r_shift     <= i_Tx_Byte;
                            r_state     <= START;
                            o_Tx_Serial <= 1'b0;
                        end else begin
                            r_state     <= IDLE;
                            o_Tx_Serial <= 1'b1;
                            o_Tx_Active <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule
